// File: rtl/mem_loader.sv
// Byte-stream boot loader: decodes load/start commands, assembles memory words and
// drives the processor's external write port, then hands memory ownership over for a run.
module mem_loader #(
  parameter int WIDTH_ACT_MEM    = 8,
  parameter int WIDTH_PARAM_MEM  = 128,
  parameter int WIDTH_INST_MEM   = 80,
  parameter int WIDTH_ADDR_ACT   = 12,
  parameter int WIDTH_ADDR_PARAM = 13,
  parameter int WIDTH_ADDR_INST  = 6
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [7:0]                  s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic                        done,
  output logic                        sel_ext,
  output logic                        en,
  output logic                        wea_instmem_ext,
  output logic                        wea_parammem_ext,
  output logic                        wea_actmem_ext,
  output logic [WIDTH_INST_MEM-1:0]   instmem_in_ext,
  output logic [WIDTH_PARAM_MEM-1:0]  parammem_in_ext,
  output logic [WIDTH_ACT_MEM-1:0]    actmem_in_ext,
  output logic [WIDTH_ADDR_INST-1:0]  addr_instmem_ext,
  output logic [WIDTH_ADDR_PARAM-1:0] addr_parammem_ext,
  output logic [WIDTH_ADDR_ACT-1:0]   addr_actmem_ext,
  output logic                        run_done,
  output logic                        cmd_err
);

  localparam int WIDTH_ASM = (WIDTH_PARAM_MEM > WIDTH_INST_MEM)
                           ? ((WIDTH_PARAM_MEM > WIDTH_ACT_MEM) ? WIDTH_PARAM_MEM : WIDTH_ACT_MEM)
                           : ((WIDTH_INST_MEM > WIDTH_ACT_MEM) ? WIDTH_INST_MEM : WIDTH_ACT_MEM);
  localparam int WIDTH_ADDR = (WIDTH_ADDR_PARAM > WIDTH_ADDR_INST)
                            ? ((WIDTH_ADDR_PARAM > WIDTH_ADDR_ACT) ? WIDTH_ADDR_PARAM : WIDTH_ADDR_ACT)
                            : ((WIDTH_ADDR_INST > WIDTH_ADDR_ACT) ? WIDTH_ADDR_INST : WIDTH_ADDR_ACT);
  localparam int LANES = WIDTH_ASM / 8;
  localparam int K_W   = $clog2(LANES + 1);

  typedef enum logic [2:0] {
    IDLE, ADDR_LO, ADDR_HI, CNT_LO, CNT_HI, DATA, WRITE, RUN
  } state_t;

  state_t                state_reg;
  logic [1:0]            tgt_reg;
  logic [WIDTH_ADDR-1:0] addr_reg;
  logic [15:0]           cnt_reg;
  logic [K_W-1:0]        k_reg;
  logic [WIDTH_ASM-1:0]  asm_reg;
  logic [WIDTH_ASM-1:0]  asm_next;
  logic                  last_lane;
  logic                  xfer;

  assign xfer = s_valid && s_ready;

  // Word as it will look once the current byte lands in lane k.
  always_comb begin
    asm_next = asm_reg;
    for (int i = 0; i < LANES; i++) begin
      if (k_reg == K_W'(i)) asm_next[i*8 +: 8] = s_data;
    end
  end

  always_comb begin
    last_lane = 1'b0;
    case (tgt_reg)
      2'd0:    last_lane = (k_reg == K_W'(WIDTH_INST_MEM / 8 - 1));
      2'd1:    last_lane = (k_reg == K_W'(WIDTH_PARAM_MEM / 8 - 1));
      default: last_lane = (k_reg == K_W'(WIDTH_ACT_MEM / 8 - 1));
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg         <= IDLE;
      tgt_reg           <= 2'd0;
      addr_reg          <= '0;
      cnt_reg           <= '0;
      k_reg             <= '0;
      asm_reg           <= '0;
      s_ready           <= 1'b0;
      sel_ext           <= 1'b1;
      en                <= 1'b0;
      wea_instmem_ext   <= 1'b0;
      wea_parammem_ext  <= 1'b0;
      wea_actmem_ext    <= 1'b0;
      instmem_in_ext    <= '0;
      parammem_in_ext   <= '0;
      actmem_in_ext     <= '0;
      addr_instmem_ext  <= '0;
      addr_parammem_ext <= '0;
      addr_actmem_ext   <= '0;
      run_done          <= 1'b0;
      cmd_err           <= 1'b0;
    end else begin
      wea_instmem_ext  <= 1'b0;
      wea_parammem_ext <= 1'b0;
      wea_actmem_ext   <= 1'b0;
      run_done         <= 1'b0;
      case (state_reg)
        IDLE: begin
          s_ready <= 1'b1;
          if (xfer) begin
            if (s_data[7:2] != 6'd0) begin
              cmd_err <= 1'b1;
            end else if (s_data[1:0] == 2'd3) begin
              state_reg <= RUN;
              sel_ext   <= 1'b0;
              en        <= 1'b1;
              s_ready   <= 1'b0;
            end else begin
              tgt_reg   <= s_data[1:0];
              state_reg <= ADDR_LO;
            end
          end
        end
        ADDR_LO: if (xfer) begin
          addr_reg[7:0] <= s_data;
          state_reg     <= ADDR_HI;
        end
        ADDR_HI: if (xfer) begin
          addr_reg  <= WIDTH_ADDR'({s_data, addr_reg[7:0]});
          state_reg <= CNT_LO;
        end
        CNT_LO: if (xfer) begin
          cnt_reg[7:0] <= s_data;
          state_reg    <= CNT_HI;
        end
        CNT_HI: if (xfer) begin
          cnt_reg[15:8] <= s_data;
          k_reg         <= '0;
          state_reg     <= ({s_data, cnt_reg[7:0]} == 16'd0) ? IDLE : DATA;
        end
        DATA: if (xfer) begin
          asm_reg <= asm_next;
          if (last_lane) begin
            // Strobe, address and data all launch together into the WRITE cycle.
            state_reg <= WRITE;
            s_ready   <= 1'b0;
            k_reg     <= '0;
            case (tgt_reg)
              2'd0: begin
                wea_instmem_ext  <= 1'b1;
                instmem_in_ext   <= asm_next[WIDTH_INST_MEM-1:0];
                addr_instmem_ext <= addr_reg[WIDTH_ADDR_INST-1:0];
              end
              2'd1: begin
                wea_parammem_ext  <= 1'b1;
                parammem_in_ext   <= asm_next[WIDTH_PARAM_MEM-1:0];
                addr_parammem_ext <= addr_reg[WIDTH_ADDR_PARAM-1:0];
              end
              default: begin
                wea_actmem_ext  <= 1'b1;
                actmem_in_ext   <= asm_next[WIDTH_ACT_MEM-1:0];
                addr_actmem_ext <= addr_reg[WIDTH_ADDR_ACT-1:0];
              end
            endcase
          end else begin
            k_reg <= k_reg + K_W'(1);
          end
        end
        WRITE: begin
          addr_reg  <= addr_reg + WIDTH_ADDR'(1);
          cnt_reg   <= cnt_reg - 16'd1;
          k_reg     <= '0;
          s_ready   <= 1'b1;
          state_reg <= (cnt_reg == 16'd1) ? IDLE : DATA;
        end
        RUN: if (done) begin
          en        <= 1'b0;
          sel_ext   <= 1'b1;
          run_done  <= 1'b1;
          s_ready   <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_loader.md
# mem_loader

Upstream boot/load sequencer for the processor top. It accepts a byte stream over a valid/ready handshake and decodes a small command protocol. It assembles bytes into instruction (80-bit), parameter (128-bit) and activation (8-bit) words and drives the processor's external memory-write port (`sel_ext`, `wea_*_ext`, `addr_*_ext`, `*_in_ext`). On a start command it hands memory ownership to the processor, holds `en` until `done`, then reclaims the memories.

## Interface
- `WIDTH_ACT_MEM`, 8: activation word width. Must be a multiple of 8.
- `WIDTH_PARAM_MEM`, 128: parameter word width. Must be a multiple of 8.
- `WIDTH_INST_MEM`, 80: instruction word width. Must be a multiple of 8.
- `WIDTH_ADDR_ACT`, 12: activation address width.
- `WIDTH_ADDR_PARAM`, 13: parameter address width.
- `WIDTH_ADDR_INST`, 6: instruction address width.
- `clk`  in  1  single clock. All logic is on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `s_data`  in  8  stream byte.
- `s_valid`  in  1  `s_data` is valid.
- `s_ready`  out  1  loader can accept a byte. A byte transfers on `s_valid && s_ready`.
- `done`  in  1  processor done, sampled only in RUN.
- `sel_ext`  out  1  1 = loader owns the memories.
- `en`  out  1  processor enable.
- `wea_instmem_ext`, `wea_parammem_ext`, `wea_actmem_ext`  out  1 each  write strobes.
- `instmem_in_ext`  out  `WIDTH_INST_MEM`  instruction write data.
- `parammem_in_ext`  out  `WIDTH_PARAM_MEM`  parameter write data.
- `actmem_in_ext`  out  `WIDTH_ACT_MEM`  activation write data.
- `addr_instmem_ext`  out  `WIDTH_ADDR_INST`  instruction write address.
- `addr_parammem_ext`  out  `WIDTH_ADDR_PARAM`  parameter write address.
- `addr_actmem_ext`  out  `WIDTH_ADDR_ACT`  activation write address.
- `run_done`  out  1  one-cycle pulse when a run completes.
- `cmd_err`  out  1  sticky illegal-command flag. Cleared only by reset.

## Operation
- Command byte format: bits [1:0] give the target (0 = inst, 1 = param, 2 = act, 3 = start). Bits [7:2] must be 0.
- A load command is followed by ADDR_LO, ADDR_HI, CNT_LO, CNT_HI, then CNT words.
- Words are sent LSB byte first. Bytes per word is the target width / 8 (inst 10, param 16, act 1).
- States: IDLE → ADDR_LO → ADDR_HI → CNT_LO → CNT_HI → DATA ⇄ WRITE → IDLE. Start command: IDLE → RUN → IDLE.
- IDLE, illegal byte: set `cmd_err`, discard the byte, stay in IDLE.
- CNT_HI with 16-bit count = 0: return to IDLE. No write occurs.
- DATA: each accepted byte shifts into the assembly register at byte lane `k`, where `k` counts 0..B-1. When byte B-1 is accepted, go to WRITE.
- WRITE (1 cycle, `s_ready` = 0):
  - Assert the target's `wea_*_ext`, the address and the assembled word. All are registered outputs.
  - Then address += 1, count -= 1, `k` = 0.
  - Next state is IDLE if the count reaches 0, otherwise DATA.
- The address is truncated to the target width. The increment wraps modulo 2^W (e.g. inst 63 → 0).
- RUN: `sel_ext` = 0, `en` = 1, `s_ready` = 0, all `wea_*_ext` = 0. On the first cycle with `done` = 1: `en` = 0, `sel_ext` = 1, pulse `run_done`, go to IDLE.
- Write data and address outputs hold their last value outside WRITE. Only the strobes are gated.

## Timing
- Reset values:
  - State IDLE.
  - `sel_ext` = 1, `en` = 0, `s_ready` = 0 during reset and 1 from the first clock after release in IDLE.
  - All `wea_*_ext` = 0, all data and address outputs = 0.
  - `run_done` = 0, `cmd_err` = 0.
- Reset asserted mid-load or mid-run aborts immediately. A partially assembled word is never written.
- `s_ready` is 1 in IDLE, ADDR_*, CNT_* and DATA, and 0 in WRITE and RUN.
- Latency: last payload byte accepted at edge N → strobe high in the cycle after edge N, for exactly one cycle.
- Throughput: one word per B+1 cycles with `s_valid` held high.
- A byte transfers only on the handshake edge. `s_valid` low stalls any state without side effects.
- RUN entry: `sel_ext` falls and `en` rises in the cycle after the start byte is accepted.
- `done` already high on the RUN entry cycle is honoured on that cycle, so RUN lasts 1 cycle.
- `run_done` is coincident with `sel_ext` returning to 1.

## Test plan
- Reset: hold `resetn` = 0 and check all reset values; release and check `s_ready` = 1 after one edge.
- Inst load: stream 00, 05, 00, 02, 00, then 20 bytes 0x01..0x14. Expect two `wea_instmem_ext` pulses:
  - addr 5, data 0x0A090807060504030201.
  - addr 6, data 0x14131211100F0E0D0C0B.
- Act load with wrap: stream 02, FF, 0F, 03, 00, AA, BB, CC. Expect writes (0xFFF, AA), (0x000, BB), (0x001, CC).
- Count zero and illegal command:
  - 01, 10, 00, 00, 00 → no write, back in IDLE.
  - 0x84 → `cmd_err` = 1, `s_ready` stays 1.
- Run: send 03 → `sel_ext` = 0, `en` = 1 next cycle. Assert `done` after 50 cycles → `en` = 0, `sel_ext` = 1, single `run_done` pulse.
- Stall/abort:
  - Param load with `s_valid` toggling every other cycle → correct 128-bit word.
  - Assert `resetn` = 0 after 9 payload bytes → no `wea_parammem_ext`, reset values restored.
